grayscale_wr_buffer: RTL and testbench

Buffers the 512-bit processed cache lines that the `grayscale` kernel produces. The kernel emits one line per `valid` pulse and cannot be stalled. This block sits between the kernel output and the write-request path of `grayscale_requestor`. It holds lines while the CCI-P write channel is throttled by `c1TxAlmFull`, and it raises `almost_full` so the requestor stops issuing reads before the kernel pipeline can overrun the buffer.

---
 rtl/grayscale_wr_buffer.sv | 111 +++++++++++
 tb/tb_grayscale_wr_buffer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grayscale_wr_buffer.sv
// Show-ahead line buffer between the grayscale kernel output and the requestor write path.
// Absorbs write-channel throttling and raises almost_full while in-flight reads still fit.
module grayscale_wr_buffer #(
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH      = 64,
    parameter int AF_SLACK   = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    valid_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic                    almost_full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic [31:0]             lines_out,
    input  logic                    clear
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH - AF_SLACK);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  overflow_q, overflow_d;
    logic [31:0]           lines_out_q, lines_out_d;

    logic [PW-1:0] occupancy;
    logic          full;
    logic          empty;
    logic          pop_fire;
    logic          push_fire;
    logic          mem_we;

    assign occupancy = wr_ptr_q - rd_ptr_q;
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign pop_fire  = !empty && ready_in;
    // A full buffer still accepts a line when the head leaves in the same cycle.
    assign push_fire = valid_in && (!full || pop_fire);
    assign mem_we    = push_fire && !clear;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        data_out_d  = data_out_q;
        overflow_d  = overflow_q;
        lines_out_d = lines_out_q;
        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            data_out_d  = '0;
            overflow_d  = 1'b0;
            lines_out_d = '0;
        end else begin
            if (pop_fire) begin
                rd_ptr_d    = rd_ptr_q + PTR_ONE;
                lines_out_d = lines_out_q + 32'd1;
            end
            if (push_fire) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else if (valid_in) begin
                overflow_d = 1'b1;
            end
            // The head register is reloaded only when the head entry changes, which keeps
            // data_out stable under stall; a new line landing at the head is bypassed.
            if (push_fire && (rd_ptr_d == wr_ptr_q)) begin
                data_out_d = data_in;
            end else if (pop_fire && (rd_ptr_d != wr_ptr_q)) begin
                data_out_d = mem[rd_ptr_d[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q[AW-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            data_out_q  <= '0;
            overflow_q  <= 1'b0;
            lines_out_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            data_out_q  <= data_out_d;
            overflow_q  <= overflow_d;
            lines_out_q <= lines_out_d;
        end
    end

    assign data_out    = data_out_q;
    assign valid_out   = !empty;
    assign count       = occupancy;
    assign almost_full = (occupancy >= AF_LEVEL);
    assign overflow    = overflow_q;
    assign lines_out   = lines_out_q;

endmodule

// File: tb/tb_grayscale_wr_buffer.sv
// Randomized bench for grayscale_wr_buffer against a queue-based reference model.
module tb_grayscale_wr_buffer;

    localparam int DW       = 512;
    localparam int DEPTH    = 64;
    localparam int AF_SLACK = 16;
    localparam int CW       = 7;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] data_in;
    logic          valid_in;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          ready_in;
    logic          almost_full;
    logic [CW-1:0] count;
    logic          overflow;
    logic [31:0]   lines_out;
    logic          clear;

    always #5 clk = ~clk;

    grayscale_wr_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_SLACK(AF_SLACK)) dut (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .valid_in(valid_in),
        .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in),
        .almost_full(almost_full), .count(count), .overflow(overflow),
        .lines_out(lines_out), .clear(clear)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] mq[$];
    bit            m_ovf;
    logic [31:0]   m_lines;

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] v;
        for (int k = 0; k < DW/32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Drives one cycle from a falling edge, updates the model at the rising edge,
    // and returns at the next falling edge where outputs are sampled.
    task automatic tick(input logic vin, input logic [DW-1:0] din, input logic rdy, input logic clr);
        bit pop, was_full;
        valid_in = vin; data_in = din; ready_in = rdy; clear = clr;
        @(posedge clk);
        was_full = (mq.size() == DEPTH);
        pop      = (mq.size() != 0) && rdy;
        if (clr) begin
            mq.delete(); m_ovf = 0; m_lines = 0;
        end else begin
            if (pop) begin
                void'(mq.pop_front());
                m_lines++;
            end
            if (vin) begin
                if (!was_full || pop) mq.push_back(din);
                else m_ovf = 1;
            end
        end
        @(negedge clk);
        valid_in = 1'b0; ready_in = 1'b0; clear = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; valid_in = 1'b0; ready_in = 1'b0; clear = 1'b0; data_in = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        mq.delete(); m_ovf = 0; m_lines = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; valid_in = 1'b0; ready_in = 1'b0; clear = 1'b0; data_in = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({valid_out, almost_full, overflow} !== 3'b000 || count !== '0 || lines_out !== '0 || data_out !== '0)
            $display("FAIL reset_outputs: got v=%b af=%b ovf=%b cnt=%0d lines=%0d data_nonzero=%b, want all 0",
                     valid_out, almost_full, overflow, count, lines_out, |data_out);
        else n_pass++;
        reset_n = 1'b1;
        mq.delete(); m_ovf = 0; m_lines = 0;
    endtask

    task automatic test_single();
        logic [DW-1:0] a5 = {64{8'hA5}};
        tick(1'b1, a5, 1'b0, 1'b0);
        n_checks++;
        if (valid_out !== 1'b1 || data_out !== a5 || count !== 7'd1)
            $display("FAIL single_push: got v=%b cnt=%0d data=%h, want v=1 cnt=1 data=%h", valid_out, count, data_out, a5);
        else n_pass++;
        tick(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (count !== 7'd0 || lines_out !== 32'd1 || valid_out !== 1'b0)
            $display("FAIL single_pop: got cnt=%0d lines=%0d v=%b, want 0 1 0", count, lines_out, valid_out);
        else n_pass++;
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 48; i++) begin
            tick(1'b1, DW'(i), 1'b0, 1'b0);
            if (i == 46) begin
                n_checks++;
                if (almost_full !== 1'b0) $display("FAIL fill_af_47: got %b want 0", almost_full);
                else n_pass++;
            end
        end
        n_checks++;
        if (almost_full !== 1'b1 || count !== 7'd48)
            $display("FAIL fill_af_48: got af=%b cnt=%0d want af=1 cnt=48", almost_full, count);
        else n_pass++;
        for (int i = 48; i < 64; i++) tick(1'b1, DW'(i), 1'b0, 1'b0);
        n_checks++;
        if (count !== 7'd64 || overflow !== 1'b0)
            $display("FAIL fill_full: got cnt=%0d ovf=%b want 64 0", count, overflow);
        else n_pass++;
        tick(1'b1, rand_line(), 1'b0, 1'b0);
        n_checks++;
        if (count !== 7'd64 || overflow !== 1'b1)
            $display("FAIL fill_drop: got cnt=%0d ovf=%b want 64 1", count, overflow);
        else n_pass++;
        for (int i = 0; i < 64; i++) begin
            n_checks++;
            if (valid_out !== 1'b1 || data_out !== DW'(i))
                $display("FAIL fill_drain_order: idx %0d got v=%b data=%h", i, valid_out, data_out);
            else n_pass++;
            tick(1'b0, '0, 1'b1, 1'b0);
        end
        n_checks++;
        if (count !== 7'd0 || valid_out !== 1'b0 || lines_out !== 32'd64 || overflow !== 1'b1)
            $display("FAIL fill_after_drain: got cnt=%0d v=%b lines=%0d ovf=%b want 0 0 64 1",
                     count, valid_out, lines_out, overflow);
        else n_pass++;
    endtask

    task automatic test_full_pushpop();
        logic [DW-1:0] lastv, seen;
        do_reset();
        for (int i = 0; i < DEPTH; i++) tick(1'b1, rand_line(), 1'b0, 1'b0);
        lastv = rand_line();
        tick(1'b1, lastv, 1'b1, 1'b0);
        n_checks++;
        if (count !== 7'd64 || overflow !== 1'b0)
            $display("FAIL full_pushpop: got cnt=%0d ovf=%b want 64 0", count, overflow);
        else n_pass++;
        seen = '0;
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (mq.size() == 0 || data_out !== mq[0]) $display("FAIL full_drain: idx %0d got %h", i, data_out);
            else n_pass++;
            seen = data_out;
            tick(1'b0, '0, 1'b1, 1'b0);
        end
        n_checks++;
        if (seen !== lastv || valid_out !== 1'b0)
            $display("FAIL full_last_out: got %h v=%b want %h v=0", seen, valid_out, lastv);
        else n_pass++;
    endtask

    task automatic test_stream();
        int pushed = 0;
        int cyc = 0;
        bit stalled = 0;
        logic [DW-1:0] held = '0;
        logic rdy, vin;
        do_reset();
        while (pushed < 1000 && cyc < 5000) begin
            rdy = 1'($urandom_range(0, 1));
            n_checks++;
            if (count !== CW'(mq.size())) $display("FAIL stream_count: got %0d want %0d", count, mq.size());
            else n_pass++;
            if (mq.size() != 0) begin
                n_checks++;
                if (valid_out !== 1'b1 || data_out !== mq[0])
                    $display("FAIL stream_data: got v=%b data=%h want %h", valid_out, data_out, mq[0]);
                else n_pass++;
            end
            if (stalled) begin
                n_checks++;
                if (data_out !== held) $display("FAIL stream_stable: got %h want %h", data_out, held);
                else n_pass++;
            end
            stalled = valid_out && !rdy;
            held    = data_out;
            vin     = !almost_full;
            tick(vin, rand_line(), rdy, 1'b0);
            if (vin) pushed++;
            cyc++;
        end
        n_checks++;
        if (pushed != 1000) $display("FAIL stream_budget: pushed %0d want 1000", pushed);
        else n_pass++;
        cyc = 0;
        while (mq.size() != 0 && cyc < 200) begin
            n_checks++;
            if (data_out !== mq[0]) $display("FAIL stream_drain: got %h want %h", data_out, mq[0]);
            else n_pass++;
            tick(1'b0, '0, 1'b1, 1'b0);
            cyc++;
        end
        n_checks++;
        if (lines_out !== 32'd1000 || overflow !== 1'b0 || count !== 7'd0 || lines_out !== m_lines)
            $display("FAIL stream_final: got lines=%0d ovf=%b cnt=%0d want 1000 0 0", lines_out, overflow, count);
        else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 3; i++) tick(1'b1, rand_line(), 1'b0, 1'b0);
        for (int i = 0; i < 200; i++) begin
            n_checks++;
            if (count !== 7'd3 || data_out !== mq[0])
                $display("FAIL wrap_pair: iter %0d got cnt=%0d data=%h want cnt=3 data=%h", i, count, data_out, mq[0]);
            else n_pass++;
            tick(1'b1, rand_line(), 1'b1, 1'b0);
        end
        n_checks++;
        if (lines_out !== 32'd200 || count !== 7'd3)
            $display("FAIL wrap_final: got lines=%0d cnt=%0d want 200 3", lines_out, count);
        else n_pass++;
    endtask

    task automatic test_clear();
        logic [DW-1:0] d;
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) tick(1'b1, rand_line(), 1'b0, 1'b0);
        for (int i = 0; i < 54; i++) tick(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (count !== 7'd10 || overflow !== 1'b1 || lines_out !== 32'd54)
            $display("FAIL clear_setup: got cnt=%0d ovf=%b lines=%0d want 10 1 54", count, overflow, lines_out);
        else n_pass++;
        tick(1'b1, rand_line(), 1'b1, 1'b1);
        n_checks++;
        if (count !== 7'd0 || valid_out !== 1'b0 || lines_out !== 32'd0 || overflow !== 1'b0)
            $display("FAIL clear_effect: got cnt=%0d v=%b lines=%0d ovf=%b want all 0", count, valid_out, lines_out, overflow);
        else n_pass++;
        d = rand_line();
        tick(1'b1, d, 1'b0, 1'b0);
        n_checks++;
        if (valid_out !== 1'b1 || data_out !== d || count !== 7'd1)
            $display("FAIL clear_resume: got v=%b cnt=%0d data=%h want 1 1 %h", valid_out, count, data_out, d);
        else n_pass++;
    endtask

    task automatic test_midreset();
        logic [DW-1:0] d;
        do_reset();
        for (int i = 0; i < 22; i++) tick(1'b1, rand_line(), 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) tick(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (count !== 7'd20 || lines_out !== 32'd2)
            $display("FAIL midreset_setup: got cnt=%0d lines=%0d want 20 2", count, lines_out);
        else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({valid_out, almost_full, overflow} !== 3'b000 || count !== '0 || lines_out !== '0 || data_out !== '0)
            $display("FAIL midreset_async: got v=%b af=%b ovf=%b cnt=%0d lines=%0d data_nonzero=%b want all 0",
                     valid_out, almost_full, overflow, count, lines_out, |data_out);
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        mq.delete(); m_ovf = 0; m_lines = 0;
        d = rand_line();
        tick(1'b1, d, 1'b0, 1'b0);
        n_checks++;
        if (valid_out !== 1'b1 || data_out !== d || count !== 7'd1)
            $display("FAIL midreset_resume: got v=%b cnt=%0d data=%h want 1 1 %h", valid_out, count, data_out, d);
        else n_pass++;
    endtask

    initial begin
        reset_n = 1'b0; valid_in = 1'b0; ready_in = 1'b0; clear = 1'b0; data_in = '0;
        test_reset();
        test_single();
        test_fill();
        test_full_pushpop();
        test_stream();
        test_wrap();
        test_clear();
        test_midreset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
